core_executor: RTL and testbench

CORE_EXECUTOR -- requirements
Module: core_executor

---
 rtl/core_executor.sv | 190 +++++++++++++++++++
 tb/tb_core_executor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_executor.sv
// Single-issue executor: eight registers, four flags, a local data RAM.
// ALU ops and moves retire in the accept cycle; loads take one extra stall cycle.
module core_executor #(
    parameter int WIDTH     = 16,
    parameter int RAM_DEPTH = 256
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic [14:0]      instrIn,
    input  logic             instrValid,
    output logic             stall,
    output logic [3:0]       flagsOut,
    input  logic [2:0]       dbgSel,
    output logic [WIDTH-1:0] dbgData
);
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SUBC = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;

    localparam logic [3:0] MOP_LOAD  = 4'h0;
    localparam logic [3:0] MOP_STORE = 4'h1;
    localparam logic [3:0] MOP_MOV   = 4'h2;

    typedef enum logic {IDLE, LOAD_WAIT} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] regs [8];
    logic             zf, of, sf, cf;
    logic [WIDTH-1:0] ram [RAM_DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [2:0]       load_rd;

    logic             is_alu;
    logic [3:0]       op, cond;
    logic [2:0]       rd, rs;
    logic [WIDTH-1:0] rd_val, rs_val;
    logic [AW-1:0]    addr;
    logic             exec, do_load, do_store;

    logic [WIDTH-1:0]   b_eff, alu_res;
    logic [WIDTH:0]     sum, shl_ext, shr_ext;
    logic [2*WIDTH-1:0] prod;
    logic               is_sub, cin, alu_c, alu_v, alu_wr_rd, alu_wr_fl;

    function automatic logic cond_pass(input logic [3:0] c, input logic z, o, s, cy);
        logic p;
        case (c)
            4'h0:    p = z;
            4'h1:    p = !z;
            4'h2:    p = !z && (s == o);
            4'h3:    p = (s != o);
            4'h4:    p = (s == o);
            4'h5:    p = z || (s != o);
            4'h6:    p = cy;
            4'h7:    p = !cy;
            4'h8:    p = s;
            4'h9:    p = !s;
            4'hA:    p = 1'b1;
            4'hB:    p = 1'b0;
            4'hC:    p = o;
            4'hD:    p = !o;
            4'hE:    p = cy && !z;
            default: p = !cy || z;
        endcase
        return p;
    endfunction

    function automatic logic add_ovf(input logic a_msb, b_msb, r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    assign {is_alu, op, cond, rd, rs} = instrIn;
    assign rd_val   = regs[rd];
    assign rs_val   = regs[rs];
    assign addr     = rs_val[AW-1:0];
    // Nothing is accepted while a load is completing; stall mirrors that.
    assign exec     = instrValid && (state == IDLE) && cond_pass(cond, zf, of, sf, cf);
    assign do_load  = exec && !is_alu && (op == MOP_LOAD);
    assign do_store = exec && !is_alu && (op == MOP_STORE);

    // Subtraction is a + ~b + cin, so CF comes out directly as no-borrow.
    assign is_sub  = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
    assign b_eff   = is_sub ? ~rs_val : rs_val;
    assign cin     = ((op == OP_ADDC) || (op == OP_SUBC)) ? cf : ((op == OP_SUB) || (op == OP_CMP));
    assign sum     = {1'b0, rd_val} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign prod    = {{WIDTH{1'b0}}, rd_val} * {{WIDTH{1'b0}}, rs_val};
    assign shl_ext = {1'b0, rd_val} << rs_val[3:0];
    assign shr_ext = {rd_val, 1'b0} >> rs_val[3:0];

    always_comb begin
        alu_res   = sum[WIDTH-1:0];
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_wr_rd = 1'b1;
        alu_wr_fl = 1'b1;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                alu_c = sum[WIDTH];
                alu_v = add_ovf(rd_val[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
            end
            OP_CMP: begin
                alu_c     = sum[WIDTH];
                alu_v     = add_ovf(rd_val[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1]);
                alu_wr_rd = 1'b0;
            end
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                alu_c   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  alu_res = rd_val & rs_val;
            OP_OR:   alu_res = rd_val | rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            OP_NOT:  alu_res = ~rs_val;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: begin
                alu_wr_rd = 1'b0;
                alu_wr_fl = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            {zf, of, sf, cf} <= 4'b0000;
            load_rd          <= '0;
        end else if (state == LOAD_WAIT) begin
            regs[load_rd] <= ram_q;
        end else if (exec) begin
            if (is_alu) begin
                if (alu_wr_rd) regs[rd] <= alu_res;
                if (alu_wr_fl) begin
                    zf <= (alu_res == '0);
                    sf <= alu_res[WIDTH-1];
                    cf <= alu_c;
                    of <= alu_v;
                end
            end else if (op == MOP_MOV) begin
                regs[rd] <= rs_val;
            end else if (op == MOP_LOAD) begin
                load_rd <= rd;
            end
        end
    end

    // RAM and its read register carry no reset so contents survive nReset.
    always_ff @(posedge clock) begin
        if (do_store) ram[addr] <= rd_val;
        if (do_load)  ram_q     <= ram[addr];
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE:      if (do_load) state_next = LOAD_WAIT;
            LOAD_WAIT: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    assign dbgData  = regs[dbgSel];
    assign flagsOut = {zf, of, sf, cf};
endmodule

// File: tb/tb_core_executor.sv
// Scoreboarded random and directed bench for core_executor against an arithmetic reference model.
module tb_core_executor;
    localparam logic [14:0] NOP = 15'b1_0000_1011_000_000;
    localparam logic [3:0]  AL = 4'hA, EQ = 4'h0, NE = 4'h1;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic [14:0] instrIn = NOP;
    logic        instrValid = 1'b0;
    logic        stall;
    logic [3:0]  flagsOut;
    logic [2:0]  dbgSel = 3'd0;
    logic [15:0] dbgData;

    core_executor #(.WIDTH(16), .RAM_DEPTH(256)) dut (
        .clock(clock), .nReset(nReset), .instrIn(instrIn), .instrValid(instrValid),
        .stall(stall), .flagsOut(flagsOut), .dbgSel(dbgSel), .dbgData(dbgData)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic [3:0]  flags;
        logic [2:0]  sel;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_reg [8];
    logic        m_z, m_o, m_s, m_c;
    logic [15:0] m_ram [256];
    bit          m_ramv [256];
    bit          m_pend;
    logic [2:0]  m_prd;
    logic [15:0] m_pval;

    function automatic logic [14:0] enc(input logic cls, input logic [3:0] op, input logic [3:0] c,
                                        input logic [2:0] rd, input logic [2:0] rs);
        return {cls, op, c, rd, rs};
    endfunction

    function automatic bit ovf16(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic bit m_cond(input logic [3:0] c);
        case (c)
            4'h0: return m_z;
            4'h1: return !m_z;
            4'h2: return !m_z && (m_s == m_o);
            4'h3: return m_s != m_o;
            4'h4: return m_s == m_o;
            4'h5: return m_z || (m_s != m_o);
            4'h6: return m_c;
            4'h7: return !m_c;
            4'h8: return m_s;
            4'h9: return !m_s;
            4'hA: return 1'b1;
            4'hB: return 1'b0;
            4'hC: return m_o;
            4'hD: return !m_o;
            4'hE: return m_c && !m_z;
            default: return !m_c || m_z;
        endcase
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        {m_z, m_o, m_s, m_c} = 4'b0000;
        m_pend = 1'b0;
    endfunction

    task automatic m_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd);
        longint ua, ub, sa, sb, r, sr, cl, bor;
        int n;
        bit c, o, wr, fl;
        logic [15:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        cl = m_c ? 1 : 0; bor = 1 - cl;
        n = int'(b[3:0]);
        c = 0; o = 0; wr = 1; fl = 1; r = 0; sr = 0;
        case (op)
            4'd0: begin r = ua + ub; sr = sa + sb; c = r > 65535; o = ovf16(sr); end
            4'd1: begin r = ua + ub + cl; sr = sa + sb + cl; c = r > 65535; o = ovf16(sr); end
            4'd2, 4'd11: begin r = ua - ub; sr = sa - sb; c = ua >= ub; o = ovf16(sr); wr = (op != 4'd11); end
            4'd3: begin r = ua - ub - bor; sr = sa - sb - bor; c = ua >= (ub + bor); o = ovf16(sr); end
            4'd4: begin r = ua * ub; c = r > 65535; end
            4'd5: r = ua & ub;
            4'd6: r = ua | ub;
            4'd7: r = ua ^ ub;
            4'd8: r = (~ub) & 65535;
            4'd9: begin r = ua << n; c = (n != 0) && (((ua >> (16 - n)) & 1) == 1); end
            4'd10: begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
            default: begin wr = 0; fl = 0; end
        endcase
        res = 16'(r & 65535);
        if (wr) m_reg[rd] = res;
        if (fl) begin
            m_z = (res == 16'h0); m_s = res[15]; m_c = c; m_o = o;
        end
    endtask

    // One clock edge of the architectural model; acc tells whether the instruction was taken.
    task automatic m_step(input bit valid, input logic [14:0] ins, output bit acc);
        logic cls; logic [3:0] op, c; logic [2:0] rd, rs; logic [15:0] a, b;
        acc = 0;
        if (m_pend) begin
            m_reg[m_prd] = m_pval;
            m_pend = 0;
            return;
        end
        if (!valid) return;
        acc = 1;
        {cls, op, c, rd, rs} = ins;
        if (!m_cond(c)) return;
        a = m_reg[rd]; b = m_reg[rs];
        if (cls) m_alu(op, a, b, rd);
        else if (op == 4'd0) begin m_pend = 1; m_prd = rd; m_pval = m_ram[b[7:0]]; end
        else if (op == 4'd1) begin m_ram[b[7:0]] = a; m_ramv[b[7:0]] = 1; end
        else if (op == 4'd2) m_reg[rd] = b;
    endtask

    function automatic void push_exp();
        exp_t e;
        e.stall = m_pend;
        e.flags = {m_z, m_o, m_s, m_c};
        e.sel   = dbgSel;
        e.data  = m_reg[dbgSel];
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++;
                $display("FAIL sb_stall t=%0t: got %b expected %b", $time, stall, e.stall);
            end
            checks++;
            if (flagsOut !== e.flags) begin
                errors++;
                $display("FAIL sb_flags t=%0t: got %b expected %b", $time, flagsOut, e.flags);
            end
            checks++;
            if (dbgData !== e.data) begin
                errors++;
                $display("FAIL sb_reg r%0d t=%0t: got %h expected %h", e.sel, $time, dbgData, e.data);
            end
        end
    end

    task automatic issue(input logic [14:0] ins);
        bit acc;
        instrIn = ins;
        instrValid = 1'b1;
        do begin
            @(posedge clock);
            m_step(1'b1, ins, acc);
            #1;
            dbgSel = 3'($urandom_range(0, 7));
            push_exp();
        end while (!acc);
        instrValid = 1'b0;
    endtask

    task automatic idle_cycle(input logic [2:0] sel);
        bit acc;
        instrValid = 1'b0;
        @(posedge clock);
        m_step(1'b0, NOP, acc);
        #1;
        dbgSel = sel;
        push_exp();
    endtask

    task automatic chk_reg(input string name, input logic [2:0] sel, input logic [15:0] exp);
        idle_cycle(sel);
        @(negedge clock);
        #1;
        check(name, dbgData, exp);
    endtask

    task automatic build_const(input logic [2:0] rd, input logic [15:0] v, input logic [2:0] s);
        issue(enc(1'b1, 4'd7, AL, s, s));
        issue(enc(1'b1, 4'd8, AL, rd, s));
        issue(enc(1'b1, 4'd2, AL, s, rd));
        issue(enc(1'b1, 4'd7, AL, rd, rd));
        for (int i = 15; i >= 0; i--) begin
            issue(enc(1'b1, 4'd9, AL, rd, s));
            if (v[i]) issue(enc(1'b1, 4'd6, AL, rd, s));
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: got running expected finished");
        finish_run();
    end

    initial begin
        logic [15:0] snap [8];
        logic [3:0]  snap_fl;
        bit acc;
        for (int i = 0; i < 256; i++) m_ramv[i] = 0;
        m_reset();

        #3;
        check("rst_stall", {15'b0, stall}, 16'h0);
        check("rst_flags", {12'b0, flagsOut}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            dbgSel = 3'(i); #1;
            check("rst_reg", dbgData, 16'h0);
        end
        @(negedge clock);
        nReset = 1'b1;

        // Carry/overflow on add
        build_const(3'd1, 16'h7FFF, 3'd7);
        build_const(3'd2, 16'h0001, 3'd7);
        build_const(3'd3, 16'h1234, 3'd7);
        issue(enc(1'b1, 4'd0, AL, 3'd1, 3'd2));
        chk_reg("add_ovf_r1", 3'd1, 16'h8000);
        check("add_ovf_flags", {12'b0, flagsOut}, 16'h0006);

        // Condition skip then take
        issue(enc(1'b0, 4'd2, EQ, 3'd3, 3'd1));
        chk_reg("mov_eq_skip", 3'd3, 16'h1234);
        issue(enc(1'b0, 4'd2, NE, 3'd3, 3'd1));
        chk_reg("mov_ne_take", 3'd3, 16'h8000);

        // Store, load with stall, back-to-back add
        build_const(3'd4, 16'h0010, 3'd0);
        build_const(3'd5, 16'hBEEF, 3'd0);
        build_const(3'd7, 16'h0005, 3'd0);
        issue(enc(1'b0, 4'd1, AL, 3'd5, 3'd4));
        issue(enc(1'b0, 4'd0, AL, 3'd6, 3'd4));
        check("load_stall_hi", {15'b0, stall}, 16'h1);
        issue(enc(1'b1, 4'd0, AL, 3'd7, 3'd2));
        check("load_stall_lo", {15'b0, stall}, 16'h0);
        chk_reg("load_r6", 3'd6, 16'hBEEF);
        chk_reg("add_once_r7", 3'd7, 16'h0006);

        // cmp then subc borrow chain
        issue(enc(1'b1, 4'd7, AL, 3'd0, 3'd0));
        build_const(3'd1, 16'h0001, 3'd7);
        issue(enc(1'b1, 4'd11, AL, 3'd0, 3'd1));
        check("cmp_flags", {12'b0, flagsOut}, 16'h0002);
        issue(enc(1'b1, 4'd3, AL, 3'd0, 3'd1));
        chk_reg("subc_r0", 3'd0, 16'hFFFE);
        check("subc_flags", {12'b0, flagsOut}, 16'h0002);

        // Idle-pattern stream leaves everything alone
        for (int i = 0; i < 8; i++) snap[i] = m_reg[i];
        snap_fl = {m_z, m_o, m_s, m_c};
        repeat (100) issue(NOP);
        for (int i = 0; i < 8; i++) chk_reg("nop_reg", 3'(i), snap[i]);
        check("nop_flags", {12'b0, flagsOut}, {12'b0, snap_fl});

        // Reset during LOAD_WAIT
        instrIn = enc(1'b0, 4'd0, AL, 3'd6, 3'd7 - 3'd3);
        instrValid = 1'b1;
        @(posedge clock);
        m_step(1'b1, instrIn, acc);
        #1;
        instrValid = 1'b0;
        dbgSel = 3'd6;
        push_exp();
        @(negedge clock);
        #1;
        nReset = 1'b0;
        m_reset();
        #1;
        check("midload_rst_stall", {15'b0, stall}, 16'h0);
        check("midload_rst_flags", {12'b0, flagsOut}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            dbgSel = 3'(i); #1;
            check("midload_rst_reg", dbgData, 16'h0);
        end
        @(negedge clock);
        nReset = 1'b1;
        chk_reg("midload_r6_zero", 3'd6, 16'h0000);
        build_const(3'd4, 16'h0010, 3'd0);
        issue(enc(1'b0, 4'd0, AL, 3'd6, 3'd4));
        chk_reg("reload_r6", 3'd6, 16'hBEEF);

        // Randomized traffic
        for (int r = 1; r < 8; r++)
            build_const(3'(r), 16'($urandom), (r == 7) ? 3'd0 : 3'd7);
        for (int k = 0; k < 400; k++) begin
            logic cls; logic [3:0] op, c; logic [2:0] rd, rs; logic [15:0] bv;
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle(3'($urandom_range(0, 7)));
            end else begin
                cls = 1'($urandom_range(0, 1));
                op  = cls ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
                c   = ($urandom_range(0, 1) == 1) ? AL : 4'($urandom_range(0, 15));
                rd  = 3'($urandom_range(0, 7));
                rs  = 3'($urandom_range(0, 7));
                bv  = (m_pend && (m_prd == rs)) ? m_pval : m_reg[rs];
                if (!cls && (op == 4'd0) && !m_ramv[bv[7:0]]) op = 4'd2;
                issue(enc(cls, op, c, rd, rs));
            end
        end

        idle_cycle(3'd0);
        @(negedge clock);
        #2;
        finish_run();
    end
endmodule
